mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_iter.sv | 127 ++++++++++++
 tb/tb_mdu_iter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  function automatic int mdu_cnt_w(int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring-subtract
// step per cycle into HI/LO, plus MTHI/MTLO writes.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = mdu_cnt_w(WIDTH);

  mdu_state_t       state, state_n;
  mdu_op_t          op_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mq, opnd;
  logic             neg_q, neg_r, dv0;

  logic             arith, sgn, a_neg, b_neg, accept, last, is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_x, add_y;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] acc_n, mq_n, q_s, r_s, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign arith  = ~op[2];
  assign sgn    = ~op[0];
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;
  assign accept = (state == IDLE) && start && arith;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign is_div = op_r[1];
  assign busy   = (state == RUN);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One adder serves both ops: multiply adds the multiplicand when the
  // multiplier LSB is set; divide subtracts the divisor from {rem, next bit}
  // and keeps the difference when no borrow comes out.
  always_comb begin
    add_x = is_div ? {acc, mq[WIDTH-1]} : {1'b0, acc};
    add_y = is_div ? ~{1'b0, opnd} : (mq[0] ? {1'b0, opnd} : '0);
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
    if (is_div) begin
      acc_n = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      mq_n  = {mq[WIDTH-2:0], sum[WIDTH+1]};
    end else begin
      acc_n = sum[WIDTH:1];
      mq_n  = {sum[0], mq[WIDTH-1:1]};
    end
  end

  // Divide by zero leaves the dividend magnitude as the remainder, so the
  // usual remainder sign fix restores the original a.
  always_comb begin
    prod   = {acc_n, mq_n};
    prod_s = neg_q ? -prod : prod;
    q_s    = dv0 ? '1 : (neg_q ? -mq_n : mq_n);
    r_s    = neg_r ? -acc_n : acc_n;
    res_hi = is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
    res_lo = is_div ? q_s : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      opnd  <= '0;
      op_r  <= OP_MULT;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dv0   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && op == OP_MTHI) hi <= a;
        if (start && op == OP_MTLO) lo <= a;
        if (accept) begin
          acc   <= '0;
          mq    <= mag_a;
          opnd  <= mag_b;
          op_r  <= op;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dv0   <= (b == '0);
          cnt   <= '0;
        end
      end else begin
        acc <= acc_n;
        mq  <= mq_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized scoreboard bench for mdu_iter against a plain-arithmetic model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  mdu_op_t     op = OP_NOP7;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  int          checks = 0, errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_e;
  logic [63:0] pend = '0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(mdu_op_t o, logic [31:0] x, logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [63:0] r;
    case (o)
      OP_MULT:  r = 64'(sx * sy);
      OP_MULTU: r = {32'd0, x} * {32'd0, y};
      OP_DIV:   r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
      OP_DIVU:  r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default:  r = {exp_hi, exp_lo};
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk("result", {hi, lo}, mon_e);
      end
      chk("busy_with_done", 64'(busy), 64'd0);
    end
  end

  task automatic issue(mdu_op_t o, logic [31:0] x, logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    if (o[2] == 1'b0) begin
      pend = model(o, x, y);
      sb_q.push_back(pend);
    end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    op = mdu_op_t'(3'($urandom_range(0, 7)));
  endtask

  // Counts busy cycles up to the done pulse, checks HI/LO hold meanwhile, and
  // optionally pokes start mid-run to show it is ignored.
  task automatic wait_done(string name, bit inj);
    int cyc = 0;
    int lim = 0;
    @(negedge clk);
    while (!done && lim < 200) begin
      if (busy) cyc++;
      chk({name, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
      if (inj && cyc == 10) begin start = 1'b1; op = OP_DIVU; end
      else start = 1'b0;
      lim++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
    chk({name, "_busy_cycles"}, 64'(cyc), 64'd32);
    {exp_hi, exp_lo} = pend;
  endtask

  task automatic directed(string name, mdu_op_t o, logic [31:0] x, logic [31:0] y,
                          logic [31:0] ehi, logic [31:0] elo, bit inj);
    issue(o, x, y);
    wait_done(name, inj);
    chk({name, "_hilo"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    mdu_op_t     ro;
    logic [31:0] ra, rb;
    #12;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    #5 reset_n = 1'b1;
    @(posedge clk); #1;

    directed("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    directed("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    directed("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    directed("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    directed("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    directed("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b0);
    directed("div_zero_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi_lo", 64'(lo), 64'(exp_lo));
    chk("mthi_flags", {62'd0, busy, done}, 64'd0);
    exp_hi = 32'hDEAD_BEEF;
    issue(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    chk("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
    chk("mtlo_flags", {62'd0, busy, done}, 64'd0);
    exp_lo = 32'h0BAD_F00D;
    issue(OP_NOP6, 32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    chk("nop_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("nop_flags", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = mdu_op_t'(3'($urandom_range(0, 3)));
      ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = 32'($urandom);
      endcase
      issue(ro, ra, rb);
      wait_done("rand", 1'b0);
    end

    issue(OP_MULTU, 32'($urandom), 32'($urandom));
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    sb_q.delete();
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    directed("multu_after_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
